// File: rtl/spi_pkg.sv
// spi_pkg: shared widths and word-size helper for the SPI receive word path
package spi_pkg;
    localparam int BYTE_W         = 8;
    localparam int DEF_WORD_BYTES = 4;

    function automatic int word_w(input int word_bytes);
        return word_bytes * BYTE_W;
    endfunction

    localparam int WORD_W = word_w(DEF_WORD_BYTES);
endpackage

// File: rtl/spi_rx_word_sync_if.sv
// spi_rx_word_sync_if: valid/ready word stream plus FIFO occupancy
interface spi_rx_word_sync_if
    import spi_pkg::*;
#(
    parameter int WORD_BYTES = DEF_WORD_BYTES,
    parameter int FIFO_DEPTH = 4
);
    logic [word_w(WORD_BYTES)-1:0] o_word_data;
    logic                          o_word_valid;
    logic                          i_word_ready;
    logic [$clog2(FIFO_DEPTH):0]   o_fifo_level;

    modport master (output o_word_data, output o_word_valid, output o_fifo_level, input i_word_ready);
    modport slave  (input o_word_data, input o_word_valid, input o_fifo_level, output i_word_ready);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead FIFO with registered level; a push while full is taken only alongside a pop
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic             full,
    output logic [AW:0]      level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign valid   = level != '0;
    assign full    = level == (AW+1)'(DEPTH);
    assign do_pop  = pop & valid;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // storage, power-of-two pointers wrap naturally, level tracks push minus pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/spi_rx_word_sync.sv
// spi_rx_word_sync: brings SPI bytes into clk via toggle handshake, packs MSB-first words, buffers them
module spi_rx_word_sync
    import spi_pkg::*;
#(
    parameter int WORD_BYTES  = DEF_WORD_BYTES,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] i_rx_byte,
    input  logic              i_rx_toggle,
    input  logic              i_ss,
    input  logic              i_clr_ovf,
    output logic              o_frame_err,
    output logic              o_overflow,
    spi_rx_word_sync_if.master word
);
    localparam int W     = word_w(WORD_BYTES);
    localparam int CNT_W = $clog2(WORD_BYTES + 1);

    logic [SYNC_STAGES-1:0] tog_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic                   tog_prev;
    logic                   ss_prev;
    logic [CNT_W-1:0]       byte_cnt;
    logic [W-BYTE_W-1:0]    asm_q;
    logic                   tog_s;
    logic                   ss_s;
    logic                   ss_rise;
    logic                   ss_fall;
    logic                   byte_evt;
    logic [W-1:0]           asm_shift;
    logic [CNT_W-1:0]       cnt_base;
    logic [CNT_W-1:0]       cnt_post;
    logic [CNT_W-1:0]       cnt_next;
    logic                   push;
    logic                   frame_err_d;
    logic                   fifo_full;
    logic                   pop;
    logic                   drop;

    assign tog_s = tog_sync[SYNC_STAGES-1];
    assign ss_s  = ss_sync[SYNC_STAGES-1];
    assign pop   = word.o_word_valid & word.i_word_ready;

    // synchronize toggle and chip select, remember last synced values for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tog_sync <= '0;
            ss_sync  <= '0;
            tog_prev <= 1'b0;
            ss_prev  <= 1'b0;
        end else begin
            tog_sync <= {tog_sync[SYNC_STAGES-2:0], i_rx_toggle};
            ss_sync  <= {ss_sync[SYNC_STAGES-2:0], i_ss};
            tog_prev <= tog_s;
            ss_prev  <= ss_s;
        end
    end

    // a byte landing on the ss-rise cycle still counts, so gating uses "high for two samples"
    always_comb begin
        ss_rise     = ss_s & ~ss_prev;
        ss_fall     = ~ss_s & ss_prev;
        byte_evt    = (tog_s ^ tog_prev) & ~(ss_s & ss_prev);
        asm_shift   = {asm_q, i_rx_byte};
        cnt_base    = ss_fall ? '0 : byte_cnt;
        push        = byte_evt && cnt_base == CNT_W'(WORD_BYTES - 1);
        cnt_post    = byte_evt ? (push ? '0 : cnt_base + 1'b1) : cnt_base;
        frame_err_d = ss_rise && cnt_post != '0;
        cnt_next    = ss_rise ? '0 : cnt_post;
        drop        = push & fifo_full & ~pop;
    end

    // assembly state, frame error pulse and sticky overflow (a new drop beats a clear)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt    <= '0;
            asm_q       <= '0;
            o_frame_err <= 1'b0;
            o_overflow  <= 1'b0;
        end else begin
            byte_cnt    <= cnt_next;
            if (byte_evt) asm_q <= asm_shift[W-BYTE_W-1:0];
            o_frame_err <= frame_err_d;
            o_overflow  <= drop | (o_overflow & ~i_clr_ovf);
        end
    end

    sync_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (asm_shift),
        .pop       (word.i_word_ready),
        .head      (word.o_word_data),
        .valid     (word.o_word_valid),
        .full      (fifo_full),
        .level     (word.o_fifo_level)
    );
endmodule
